mips_debug_unit: RTL and testbench
==================================

# mips_debug_unit

Parametrised debug controller for the pipelined MIPS core. It receives a byte stream from the host link and loads program words into instruction memory through the core's debug write port. It runs the core either continuously until halt or one cycle at a time. After each run it snapshots the PC, a cycle counter and `n_latch` pipeline-latch words, then streams them back byte by byte with a valid/ready handshake.

## Interface
- `len_data`, 32: data/instruction word width; must be a multiple of 8 (`nbytes = len_data/8`).
- `len_addr`, 8: instruction-memory address width.
- `n_latch`, 4: number of pipeline-latch words captured per dump.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; returns every register to its reset value immediately.
- `in_byte` in 8: host command/data byte.
- `in_valid` in 1: `in_byte` valid; a byte is accepted on an edge with `in_valid && in_ready`.
- `in_ready` out 1: unit can accept a byte.
- `out_byte` out 8: dump byte.
- `out_valid` out 1: `out_byte` valid.
- `out_ready` in 1: host accepts `out_byte`.
- `cpu_enable` out 1: core clock enable / step.
- `debug_flag` out 1: routes the instruction-memory port to the debug address.
- `out_addr_mem_inst` out `len_addr`: debug write address.
- `out_ins_to_mem` out `len_data`: debug write data.
- `wea_ram_inst` out 1: instruction-memory write strobe.
- `in_pc` in `len_addr`: core PC.
- `in_halt_flag` in 1: core halt (end of WB stage).
- `in_latches` in `n_latch*len_data`: flattened latch words; word k is bits `[k*len_data +: len_data]`.

## Operation
- States: IDLE, LOAD_CNT, LOAD_DATA, LOAD_WRITE, RUN, STEP, SNAP, DUMP.
- Reset values:
  - state IDLE.
  - `cpu_enable`, `debug_flag`, `wea_ram_inst`, `out_valid` all 0.
  - `in_ready` 1.
  - Address, data, cycle counter and snapshot registers all 0.
- IDLE (`in_ready`=1) decodes the accepted byte:
  - 0x4C 'L' → LOAD_CNT.
  - 0x43 'C' → RUN.
  - 0x53 'S' → STEP.
  - Any other byte is dropped; state stays IDLE.
- LOAD_CNT:
  - The accepted byte N is the word count; `debug_flag`←1 and the word index←0.
  - N=0 → IDLE with `debug_flag`←0.
  - Otherwise → LOAD_DATA.
- LOAD_DATA:
  - Shifts in `nbytes` bytes, MSB first, into `out_ins_to_mem`.
  - After the last byte → LOAD_WRITE.
- LOAD_WRITE:
  - Exactly one cycle with `wea_ram_inst`=1, `in_ready`=0 and `out_addr_mem_inst` = the word index.
  - Then the index increments, wrapping mod 2^`len_addr`.
  - If N words are now written → IDLE with `debug_flag`←0; else → LOAD_DATA.
- RUN:
  - `cpu_enable`=1 throughout.
  - On the edge where `in_halt_flag`=1, `cpu_enable`←0 and the state → SNAP.
- STEP: `cpu_enable`=1 for exactly one cycle, then → SNAP.
- Cycle counter (`len_data` bits):
  - Increments on every edge where `cpu_enable`=1.
  - Saturates at all-ones.
  - Cleared only by reset.
- SNAP (one cycle, `cpu_enable`=0):
  - Captures the dump frame in this order: {zero-extended `in_pc`, cycle counter, latch word 0 … latch word n_latch-1}.
  - The frame is `(2+n_latch)*nbytes` bytes.
  - Then → DUMP.
- DUMP:
  - `out_valid`=1 and `in_ready`=0.
  - Bytes are emitted word by word, each word MSB first.
  - `out_byte` advances only on an edge with `out_ready`=1.
  - After the last byte transfers, `out_valid`←0 and the state → IDLE.
- If the core is already halted, 'C' enables exactly one cycle and then dumps.

## Timing
- A command accepted at edge t makes `cpu_enable` high from edge t onward (registered output).
- Halt latency: `in_halt_flag` seen at edge t gives `cpu_enable` low after t; the snapshot is taken at edge t+1.
- Load: the last data byte accepted at edge t gives `wea_ram_inst` high during cycle t..t+1 only.
- `out_byte` is stable while `out_valid && !out_ready`. No byte is skipped or repeated.
- `in_valid` while `in_ready`=0 is ignored; the host must hold the byte.
- Reset mid-operation:
  - Any partial word is discarded with no write strobe.
  - `cpu_enable` drops asynchronously.
  - Any dump in progress is abandoned.

## Test plan
- Reset asserted → all outputs at their reset values, `in_ready`=1, state IDLE, counter 0.
- Bytes 'L',0x02,11,22,33,44,55,66,77,88 → `wea_ram_inst` pulses: addr 0 with data 0x11223344, then addr 1 with data 0x55667788. `debug_flag` high from after the count byte until after the second write. Returns to IDLE.
- After reset, 'S' with `in_pc`=0x05 and latches 0xA0..0xA3 → `cpu_enable` high exactly 1 cycle. Dump is 24 bytes: 00 00 00 05, 00 00 00 01, 00 00 00 A0, …, 00 00 00 A3.
- After reset, 'C' with `in_halt_flag` raised during the 10th enabled cycle → `cpu_enable` high exactly 10 cycles; dumped counter = 0x0000000A.
- `out_ready` held low 5 cycles mid-dump → `out_byte` constant during the stall; the full 24-byte frame is received intact.
- `reset` pulsed after 2 of 4 data bytes in LOAD_DATA → no `wea_ram_inst` pulse; `debug_flag`=0; IDLE; a following 'L' load completes normally at addr 0.

Source files
------------

// File: rtl/mips_debug_unit.sv
// Host-driven debug controller: loads instruction words, runs or steps the core,
// then snapshots PC, cycle count and pipeline latches and streams them out byte-wise.
module mips_debug_unit #(
  parameter int len_data = 32,
  parameter int len_addr = 8,
  parameter int n_latch  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_byte,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [7:0]                  out_byte,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        cpu_enable,
  output logic                        debug_flag,
  output logic [len_addr-1:0]         out_addr_mem_inst,
  output logic [len_data-1:0]         out_ins_to_mem,
  output logic                        wea_ram_inst,
  input  logic [len_addr-1:0]         in_pc,
  input  logic                        in_halt_flag,
  input  logic [n_latch*len_data-1:0] in_latches
);

  localparam int nbytes      = len_data / 8;
  localparam int frame_bytes = (2 + n_latch) * nbytes;
  localparam int frame_w     = frame_bytes * 8;
  localparam int bw          = $clog2(nbytes) + 1;
  localparam int dw          = $clog2(frame_bytes) + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD_CNT, LOAD_DATA, LOAD_WRITE, RUN, STEP, SNAP, DUMP
  } state_t;

  state_t               state, state_nx;
  logic [7:0]           word_n;
  logic [7:0]           words_done;
  logic [len_addr-1:0]  word_idx;
  logic [bw-1:0]        byte_cnt;
  logic [len_data-1:0]  ins_word;
  logic [len_data-1:0]  cycle_cnt;
  logic [frame_w-1:0]   frame;
  logic [frame_w-1:0]   snap_frame;
  logic [dw-1:0]        dump_cnt;
  logic                 accept;
  logic                 last_data_byte;
  logic                 last_dump_byte;

  assign accept            = in_valid && in_ready;
  assign last_data_byte    = (byte_cnt == bw'(nbytes - 1));
  assign last_dump_byte    = (dump_cnt == dw'(frame_bytes - 1));
  assign out_byte          = frame[frame_w-1 -: 8];
  assign out_ins_to_mem    = ins_word;
  assign out_addr_mem_inst = word_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
        case (in_byte)
          8'h4C:   state_nx = LOAD_CNT;
          8'h43:   state_nx = RUN;
          8'h53:   state_nx = STEP;
          default: state_nx = IDLE;
        endcase
      end
      LOAD_CNT:   if (accept) state_nx = (in_byte == 8'd0) ? IDLE : LOAD_DATA;
      LOAD_DATA:  if (accept && last_data_byte) state_nx = LOAD_WRITE;
      LOAD_WRITE: state_nx = (words_done + 8'd1 == word_n) ? IDLE : LOAD_DATA;
      RUN:        if (in_halt_flag) state_nx = SNAP;
      STEP:       state_nx = SNAP;
      SNAP:       state_nx = DUMP;
      DUMP:       if (out_ready && last_dump_byte) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    cpu_enable   = 1'b0;
    debug_flag   = 1'b0;
    wea_ram_inst = 1'b0;
    out_valid    = 1'b0;
    case (state)
      IDLE, LOAD_CNT: in_ready = 1'b1;
      LOAD_DATA: begin
        in_ready   = 1'b1;
        debug_flag = 1'b1;
      end
      LOAD_WRITE: begin
        debug_flag   = 1'b1;
        wea_ram_inst = 1'b1;
      end
      RUN, STEP: cpu_enable = 1'b1;
      DUMP:      out_valid  = 1'b1;
      default: ;
    endcase
  end

  // Frame is laid out MSB-first so the dump is a plain left shift: PC, counter, latch 0..n-1.
  always_comb begin
    snap_frame = '0;
    snap_frame[frame_w-1 -: len_data]          = len_data'(in_pc);
    snap_frame[frame_w-1-len_data -: len_data] = cycle_cnt;
    for (int k = 0; k < n_latch; k++)
      snap_frame[(n_latch-1-k)*len_data +: len_data] = in_latches[k*len_data +: len_data];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_n     <= '0;
      words_done <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      ins_word   <= '0;
      cycle_cnt  <= '0;
      frame      <= '0;
      dump_cnt   <= '0;
    end else begin
      if (cpu_enable && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + len_data'(1);
      case (state)
        LOAD_CNT: if (accept) begin
          word_n     <= in_byte;
          words_done <= '0;
          word_idx   <= '0;
          byte_cnt   <= '0;
        end
        LOAD_DATA: if (accept) begin
          ins_word <= (ins_word << 8) | len_data'(in_byte);
          byte_cnt <= last_data_byte ? '0 : byte_cnt + bw'(1);
        end
        LOAD_WRITE: begin
          word_idx   <= word_idx + len_addr'(1);
          words_done <= words_done + 8'd1;
        end
        SNAP: begin
          frame    <= snap_frame;
          dump_cnt <= '0;
        end
        DUMP: if (out_ready) begin
          frame    <= frame << 8;
          dump_cnt <= dump_cnt + dw'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_debug_unit.sv
// Directed bench for mips_debug_unit: load, step, run-to-halt, stalled dump, reset mid-load.
module tb_mips_debug_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready;
  logic         cpu_enable;
  logic         debug_flag;
  logic [7:0]   out_addr_mem_inst;
  logic [31:0]  out_ins_to_mem;
  logic         wea_ram_inst;
  logic [7:0]   in_pc;
  logic         in_halt_flag;
  logic [127:0] in_latches;

  int tot = 0;
  int bad = 0;

  logic [7:0]  wq_addr[$];
  logic [31:0] wq_dat[$];
  int          en_total = 0;

  logic [7:0]  got[24];
  int          got_n;
  int          stall_changes;

  mips_debug_unit #(.len_data(32), .len_addr(8), .n_latch(4)) dut (
    .clk(clk), .reset(reset),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .cpu_enable(cpu_enable), .debug_flag(debug_flag),
    .out_addr_mem_inst(out_addr_mem_inst), .out_ins_to_mem(out_ins_to_mem),
    .wea_ram_inst(wea_ram_inst),
    .in_pc(in_pc), .in_halt_flag(in_halt_flag), .in_latches(in_latches)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wea_ram_inst) begin
      wq_addr.push_back(out_addr_mem_inst);
      wq_dat.push_back(out_ins_to_mem);
    end
    if (cpu_enable) en_total++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] pc, input logic [31:0] cnt);
    logic [31:0] w;
    case (i / 4)
      0:       w = pc;
      1:       w = cnt;
      default: w = 32'hA0 + 32'(i / 4 - 2);
    endcase
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      if (in_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1 in_valid = 1'b0;
    tot++;
    if (!done) begin
      bad++;
      $display("FAIL send_byte %02h: accepted=0 required=1", b);
    end
  endtask

  task automatic collect_dump(input int stall_at);
    logic [7:0] held;
    got_n = 0;
    stall_changes = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 400 && got_n < 24; c++) begin
      @(negedge clk);
      if (got_n == stall_at && out_valid) begin
        held = out_byte;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (out_byte !== held || out_valid !== 1'b1) stall_changes++;
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        got[got_n] = out_byte;
        got_n++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_byte = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = 8'h00; in_halt_flag = 1'b0;
    for (int k = 0; k < 4; k++) in_latches[k*32 +: 32] = 32'hA0 + 32'(k);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tot++;
    if ({in_ready, cpu_enable, debug_flag, wea_ram_inst, out_valid} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 10000",
               {in_ready, cpu_enable, debug_flag, wea_ram_inst, out_valid});
    end
    tot++;
    if (out_addr_mem_inst !== 8'h00 || out_ins_to_mem !== 32'h0 || out_byte !== 8'h00) begin
      bad++;
      $display("FAIL reset_regs: addr=%h data=%h byte=%h required zeros",
               out_addr_mem_inst, out_ins_to_mem, out_byte);
    end
    reset = 1'b0;
  endtask

  task automatic test_load();
    int q0 = wq_addr.size();
    send_byte(8'h4C);
    tot++;
    if (debug_flag !== 1'b0) begin bad++; $display("FAIL load_cnt_dbg: got %b required 0", debug_flag); end
    send_byte(8'h02);
    tot++;
    if (debug_flag !== 1'b1) begin bad++; $display("FAIL load_dbg_on: got %b required 1", debug_flag); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    @(negedge clk);
    tot++;
    if ({wea_ram_inst, in_ready, debug_flag} !== 3'b101 || out_addr_mem_inst !== 8'd1
        || out_ins_to_mem !== 32'h55667788) begin
      bad++;
      $display("FAIL load_write2: wea/rdy/dbg=%b addr=%h data=%h required 101 01 55667788",
               {wea_ram_inst, in_ready, debug_flag}, out_addr_mem_inst, out_ins_to_mem);
    end
    @(negedge clk);
    tot++;
    if ({wea_ram_inst, in_ready, debug_flag} !== 3'b010) begin
      bad++;
      $display("FAIL load_done: wea/rdy/dbg=%b required 010", {wea_ram_inst, in_ready, debug_flag});
    end
    tot++;
    if (wq_addr.size() - q0 != 2) begin
      bad++;
      $display("FAIL load_nwrites: got %0d required 2", wq_addr.size() - q0);
    end else begin
      tot++;
      if (wq_addr[q0] !== 8'd0 || wq_dat[q0] !== 32'h11223344 ||
          wq_addr[q0+1] !== 8'd1 || wq_dat[q0+1] !== 32'h55667788) begin
        bad++;
        $display("FAIL load_writes: %h:%h %h:%h required 00:11223344 01:55667788",
                 wq_addr[q0], wq_dat[q0], wq_addr[q0+1], wq_dat[q0+1]);
      end
    end
  endtask

  task automatic test_idle_misc();
    int q0 = wq_addr.size();
    send_byte(8'h4C);
    send_byte(8'h00);
    @(negedge clk);
    tot++;
    if ({in_ready, debug_flag} !== 2'b10 || wq_addr.size() != q0) begin
      bad++;
      $display("FAIL zero_count: rdy/dbg=%b writes=%0d required 10 0",
               {in_ready, debug_flag}, wq_addr.size() - q0);
    end
    send_byte(8'h58);
    @(negedge clk);
    tot++;
    if ({in_ready, cpu_enable, debug_flag, out_valid} !== 4'b1000) begin
      bad++;
      $display("FAIL drop_byte: rdy/en/dbg/ov=%b required 1000",
               {in_ready, cpu_enable, debug_flag, out_valid});
    end
  endtask

  task automatic test_step();
    int e0;
    do_reset();
    in_pc = 8'h05;
    e0 = en_total;
    send_byte(8'h53);
    collect_dump(-1);
    @(negedge clk);
    tot++;
    if (en_total - e0 != 1) begin bad++; $display("FAIL step_enable: got %0d cycles required 1", en_total - e0); end
    tot++;
    if (got_n != 24) begin bad++; $display("FAIL step_len: got %0d bytes required 24", got_n); end
    for (int i = 0; i < got_n; i++) begin
      tot++;
      if (got[i] !== exp_byte(i, 32'h05, 32'h1)) begin
        bad++;
        $display("FAIL step_byte[%0d]: got %h required %h", i, got[i], exp_byte(i, 32'h05, 32'h1));
      end
    end
    tot++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL step_end: ov/rdy=%b required 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_run();
    int e0;
    int en = 0;
    do_reset();
    in_pc = 8'h3C;
    e0 = en_total;
    send_byte(8'h43);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (cpu_enable) en++;
      if (en == 10) begin
        in_halt_flag = 1'b1;
        break;
      end
    end
    @(negedge clk);
    in_halt_flag = 1'b0;
    tot++;
    if (cpu_enable !== 1'b0) begin bad++; $display("FAIL run_halt: cpu_enable=%b required 0", cpu_enable); end
    collect_dump(-1);
    @(negedge clk);
    tot++;
    if (en_total - e0 != 10) begin bad++; $display("FAIL run_enable: got %0d cycles required 10", en_total - e0); end
    tot++;
    if (got_n != 24) begin bad++; $display("FAIL run_len: got %0d bytes required 24", got_n); end
    for (int i = 0; i < got_n; i++) begin
      tot++;
      if (got[i] !== exp_byte(i, 32'h3C, 32'hA)) begin
        bad++;
        $display("FAIL run_byte[%0d]: got %h required %h", i, got[i], exp_byte(i, 32'h3C, 32'hA));
      end
    end
  endtask

  task automatic test_back_to_back();
    in_pc = 8'h07;
    send_byte(8'h53);
    collect_dump(9);
    @(negedge clk);
    tot++;
    if (stall_changes != 0) begin bad++; $display("FAIL stall_hold: %0d changes required 0", stall_changes); end
    tot++;
    if (got_n != 24) begin bad++; $display("FAIL stall_len: got %0d bytes required 24", got_n); end
    for (int i = 0; i < got_n; i++) begin
      tot++;
      if (got[i] !== exp_byte(i, 32'h07, 32'hB)) begin
        bad++;
        $display("FAIL stall_byte[%0d]: got %h required %h", i, got[i], exp_byte(i, 32'h07, 32'hB));
      end
    end
    tot++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_end: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int q0;
    send_byte(8'h43);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tot++;
    if (cpu_enable !== 1'b0) begin bad++; $display("FAIL async_drop: cpu_enable=%b required 0", cpu_enable); end
    @(negedge clk);
    reset = 1'b0;
    q0 = wq_addr.size();
    send_byte(8'h4C); send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD);
    @(negedge clk);
    reset = 1'b1;
    #1;
    tot++;
    if ({in_ready, debug_flag, wea_ram_inst} !== 3'b100 || out_ins_to_mem !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset: rdy/dbg/wea=%b data=%h required 100 00000000",
               {in_ready, debug_flag, wea_ram_inst}, out_ins_to_mem);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tot++;
    if (wq_addr.size() != q0) begin bad++; $display("FAIL mid_nowrite: got %0d writes required 0", wq_addr.size() - q0); end
    send_byte(8'h4C); send_byte(8'h01);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
    repeat (2) @(negedge clk);
    tot++;
    if (wq_addr.size() != q0 + 1) begin
      bad++;
      $display("FAIL reload_n: got %0d writes required 1", wq_addr.size() - q0);
    end else begin
      tot++;
      if (wq_addr[q0] !== 8'd0 || wq_dat[q0] !== 32'hCAFEBABE) begin
        bad++;
        $display("FAIL reload_write: %h:%h required 00:cafebabe", wq_addr[q0], wq_dat[q0]);
      end
    end
    tot++;
    if ({in_ready, debug_flag} !== 2'b10) begin
      bad++;
      $display("FAIL reload_idle: rdy/dbg=%b required 10", {in_ready, debug_flag});
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_idle_misc();
    test_step();
    test_run();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
